dmem_arbiter: RTL and testbench
===============================

# dmem_arbiter

Two-requester arbiter and sequencer for the single-ported synchronous data memory. It sits between the memory and two masters: the datapath's load/store path (core) and an external loader/debug port (ext). It grants one access at a time, drives the memory for exactly one cycle per access, returns read data with a done pulse, and gives the datapath a stall signal so the PC holds while a load or store is in flight.

## Interface
- `ADDR_W`, 32, byte-address width.
- `DATA_W`, 32, data word width.

- `clk`  in  1  system clock; all state updates on the rising edge.
- `reset`  in  1  asynchronous, active-low reset: asserted when 0.
- `core_req`  in  1  core access request; held until `core_done`.
- `core_we`  in  1  1 = store, 0 = load; stable while `core_req` is 1.
- `core_addr`  in  ADDR_W  byte address (ALU result).
- `core_wdata`  in  DATA_W  store data.
- `core_rdata`  out  DATA_W  load data, valid in the `core_done` cycle and held afterwards.
- `core_done`  out  1  one-cycle completion pulse.
- `core_stall`  out  1  `core_req & ~core_done` (combinational).
- `ext_req`, `ext_we`, `ext_addr`, `ext_wdata`, `ext_rdata`, `ext_done`: same semantics for the ext master.
- `mem_en`  out  1  memory access strobe, exactly one cycle per grant.
- `mem_we`  out  1  write enable; asserted only when `mem_en` is 1.
- `mem_addr`  out  ADDR_W  word-aligned address `{addr[ADDR_W-1:2], 2'b00}`.
- `mem_wdata`  out  DATA_W  write data.
- `mem_rdata`  in  DATA_W  read data, valid one cycle after `mem_en`.
- `gnt_ext`  out  1  1 while the current or last grant belongs to ext.

## Operation
- **FSM states:** IDLE, ISSUE, RESP.
- **IDLE:**
  - With no request, stay in IDLE.
  - With any request, select a winner, register its `we`, `addr` and `wdata` onto the `mem_*` outputs, and go to ISSUE.
- **ISSUE:**
  - `mem_en` = 1, `mem_we` = latched `we`.
  - Go to RESP.
- **RESP:**
  - `mem_en` = 0.
  - On a read, capture `mem_rdata` into the winner's `rdata` register.
  - Pulse the winner's `done`.
  - Go to IDLE.
- **Arbitration:** round-robin on simultaneous requests. The loser is the master that won the previous grant; the last-grant register is set to ext at reset, so core wins the first contention. A single requester always wins.
- **Writes:** a write also produces a `done` pulse. The master's `rdata` is unchanged on a write.
- **Losing requester:** keeps `req` high. It wins at the next IDLE cycle, so there is no starvation.
- **Misaligned addresses:** bits [1:0] are ignored. There are no byte or halfword accesses.
- **Request sampling:** `req`, `we`, `addr` and `wdata` are sampled only in IDLE. Changes in ISSUE or RESP have no effect on the access in flight.
- **`core_stall`:** held high from the cycle `core_req` rises until the `core_done` cycle. The datapath advances the PC on the edge that ends the `done` cycle.

## Timing
- **Latency:** request sampled at edge N (IDLE) → `mem_en` high in cycle N+1 → `done` and `rdata` valid in cycle N+2 → back in IDLE in cycle N+3. A request still high in N+3 is treated as a new transaction.
- **Throughput:** 1 access per 3 cycles.
- **Reset values:**
  - State = IDLE.
  - `mem_en`, `mem_we`, `core_done`, `ext_done` = 0.
  - `mem_addr`, `mem_wdata`, `core_rdata`, `ext_rdata` = 0.
  - Last-grant = ext, so `gnt_ext` = 1.
- **Reset during ISSUE:** `mem_we` is cleared asynchronously, so no write is committed after reset assertion. The access is dropped and no `done` is issued. After reset the requester sees a fresh IDLE and must retry (hold `req`).
- **Reset deassertion:** the first grant can occur at the first rising edge with `reset` = 1.
- **Mutual exclusion:** `core_done` and `ext_done` are never high in the same cycle.

## Test plan
- **Single core write:** core store, addr 0x0000_0004, data 0x0000_000F. Expect `mem_en` = `mem_we` = 1 for one cycle at N+1 with `mem_addr` = 0x4, `core_done` at N+2, and `core_stall` = 1 in N and N+1, 0 in N+2.
- **Read latency:** memory preloaded with word 1 = 0xDEAD_BEEF; core load at 0x0000_0006. Expect `mem_addr` = 0x4 and `core_rdata` = 0xDEAD_BEEF together with `core_done` at N+2.
- **Contention:** both masters request continuously from reset. Expect grant order core, ext, core, ext; `done` pulses every 3 cycles, alternating.
- **Back-to-back writes:** ext holds `req` with `we` = 1, writing 0x11 then 0x22 to addresses 0x8 and 0xC. Expect both words in memory after 6 cycles and `ext_rdata` unchanged at 0.
- **Reset in ISSUE:** pull `reset` low during the ISSUE cycle of a core store to 0x10. Expect memory[0x10] unchanged, no `core_done`, and all outputs at their reset values.
- **Program run:** datapath running a short program of addi, add and sw x3, 0(x0) with x3 = 15, then lw x6, 0(x0) through the arbiter. Expect x6 = 15 and the PC to hold for exactly 2 extra cycles on each memory instruction.

Source files
------------

// File: rtl/dmem_arbiter.sv
// dmem_arbiter: two-master (core, ext) arbiter and sequencer for a single-ported
// synchronous data memory. One access at a time takes three cycles:
// IDLE (select) -> ISSUE (memory strobe) -> RESP (done pulse, read data).
module dmem_arbiter #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              core_req,
  input  logic              core_we,
  input  logic [ADDR_W-1:0] core_addr,
  input  logic [DATA_W-1:0] core_wdata,
  output logic [DATA_W-1:0] core_rdata,
  output logic              core_done,
  output logic              core_stall,
  input  logic              ext_req,
  input  logic              ext_we,
  input  logic [ADDR_W-1:0] ext_addr,
  input  logic [DATA_W-1:0] ext_wdata,
  output logic [DATA_W-1:0] ext_rdata,
  output logic              ext_done,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              gnt_ext
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    RESP  = 2'd2
  } state_t;

  // Clearing the two low address bits forces word alignment; there are no
  // sub-word accesses.
  localparam logic [ADDR_W-1:0] ALIGN_MASK = ~ADDR_W'(3);

  state_t            state;
  state_t            state_nxt;
  logic              grant;
  logic              sel_ext;
  logic              last_ext;
  logic              we_q;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] wdata_q;
  logic [DATA_W-1:0] core_rdata_q;
  logic [DATA_W-1:0] ext_rdata_q;

  // Round-robin winner: on contention the previous winner loses; a lone
  // requester always wins.
  always_comb begin
    sel_ext = ext_req & (~core_req | ~last_ext);
    grant   = (state == IDLE) & (core_req | ext_req);
  end

  // State register; an asynchronous reset drops any access in flight.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_nxt;
  end

  // Next state and per-state strobes. mem_we is gated by ISSUE, so it falls
  // with the asynchronous state reset and no write can land after reset.
  always_comb begin
    state_nxt = state;
    mem_en    = 1'b0;
    mem_we    = 1'b0;
    core_done = 1'b0;
    ext_done  = 1'b0;
    case (state)
      IDLE: begin
        if (core_req | ext_req) state_nxt = ISSUE;
      end
      ISSUE: begin
        mem_en    = 1'b1;
        mem_we    = we_q;
        state_nxt = RESP;
      end
      RESP: begin
        core_done = ~last_ext;
        ext_done  = last_ext;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Latch the winner's access in IDLE; request changes later in the
  // transaction do not disturb it. last_ext also names the current winner.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      last_ext <= 1'b1;
      we_q     <= 1'b0;
      addr_q   <= '0;
      wdata_q  <= '0;
    end else if (grant) begin
      last_ext <= sel_ext;
      we_q     <= sel_ext ? ext_we : core_we;
      addr_q   <= (sel_ext ? ext_addr : core_addr) & ALIGN_MASK;
      wdata_q  <= sel_ext ? ext_wdata : core_wdata;
    end
  end

  // Hold the last read word per master; writes leave it untouched.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      core_rdata_q <= '0;
      ext_rdata_q  <= '0;
    end else if ((state == RESP) && !we_q) begin
      if (last_ext) ext_rdata_q  <= mem_rdata;
      else          core_rdata_q <= mem_rdata;
    end
  end

  // Read data must already be valid in the done cycle, so the memory output
  // is passed straight through then and the held copy is used afterwards.
  always_comb begin
    core_rdata = (core_done & ~we_q) ? mem_rdata : core_rdata_q;
    ext_rdata  = (ext_done  & ~we_q) ? mem_rdata : ext_rdata_q;
    core_stall = core_req & ~core_done;
    mem_addr   = addr_q;
    mem_wdata  = wdata_q;
    gnt_ext    = last_ext;
  end

endmodule

// File: tb/tb_dmem_arbiter.sv
// tb_dmem_arbiter: scoreboard bench for dmem_arbiter with a behavioural
// synchronous memory and a tiny datapath model for the program run.
module tb_dmem_arbiter;
  localparam int AW = 32;
  localparam int DW = 32;

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic          core_req = 1'b0, core_we = 1'b0;
  logic [AW-1:0] core_addr = '0;
  logic [DW-1:0] core_wdata = '0;
  logic [DW-1:0] core_rdata;
  logic          core_done, core_stall;
  logic          ext_req = 1'b0, ext_we = 1'b0;
  logic [AW-1:0] ext_addr = '0;
  logic [DW-1:0] ext_wdata = '0;
  logic [DW-1:0] ext_rdata;
  logic          ext_done;
  logic          mem_en, mem_we;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic [DW-1:0] mem_rdata = '0;
  logic          gnt_ext;

  always #5 clk = ~clk;

  dmem_arbiter #(.ADDR_W(AW), .DATA_W(DW)) dut (
    .clk(clk), .reset(reset),
    .core_req(core_req), .core_we(core_we), .core_addr(core_addr),
    .core_wdata(core_wdata), .core_rdata(core_rdata), .core_done(core_done),
    .core_stall(core_stall),
    .ext_req(ext_req), .ext_we(ext_we), .ext_addr(ext_addr),
    .ext_wdata(ext_wdata), .ext_rdata(ext_rdata), .ext_done(ext_done),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .gnt_ext(gnt_ext)
  );

  // Synchronous single-port memory, 16 words.
  logic [31:0] tmem [16];
  logic [31:0] ref_mem [16];
  always @(posedge clk) begin
    if (mem_en) begin
      if (mem_we) tmem[mem_addr[5:2]] <= mem_wdata;
      else        mem_rdata <= tmem[mem_addr[5:2]];
    end
  end

  int errs = 0;
  int checks = 0;

  task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, act, exp, $time);
    end
  endtask

  typedef struct {
    bit          is_ext;
    bit          we;
    logic [31:0] rdata;
  } exp_t;
  exp_t sb[$];
  logic [31:0] exp_core_rd = '0;
  logic [31:0] exp_ext_rd = '0;

  // Reference model: expected rdata comes from ref_mem in grant order.
  task automatic push_exp(input bit is_ext, input bit we, input logic [31:0] addr,
                          input logic [31:0] wdata);
    exp_t e;
    e.is_ext = is_ext;
    e.we     = we;
    if (we) begin
      ref_mem[addr[5:2]] = wdata;
      e.rdata = is_ext ? exp_ext_rd : exp_core_rd;
    end else begin
      e.rdata = ref_mem[addr[5:2]];
      if (is_ext) exp_ext_rd = e.rdata;
      else        exp_core_rd = e.rdata;
    end
    sb.push_back(e);
  endtask

  int cyc = 0;
  int done_t[$];
  exp_t mon_e;
  always @(posedge clk) cyc++;

  // Monitor: every done pulse is matched against the scoreboard head.
  always @(negedge clk) begin
    if (mem_we) chk("we_without_en", mem_en, 1);
    if (core_done || ext_done) begin
      chk("done_mutex", core_done & ext_done, 0);
      done_t.push_back(cyc);
      if (sb.size() == 0) chk("unexpected_done", 1, 0);
      else begin
        mon_e = sb.pop_front();
        chk("grant_master", ext_done, mon_e.is_ext);
        chk("rdata", mon_e.is_ext ? ext_rdata : core_rdata, mon_e.rdata);
      end
    end
  end

  // One access by one master; called #1 after a rising edge, returns likewise.
  task automatic xfer(input bit is_ext, input bit we, input logic [31:0] addr,
                      input logic [31:0] wdata, input bit keep);
    bit seen = 0;
    if (is_ext) begin
      ext_req = 1; ext_we = we; ext_addr = addr; ext_wdata = wdata;
    end else begin
      core_req = 1; core_we = we; core_addr = addr; core_wdata = wdata;
    end
    for (int i = 0; i < 30 && !seen; i++) begin
      @(negedge clk);
      seen = is_ext ? ext_done : core_done;
    end
    if (!seen) chk("done_timeout", 0, 1);
    @(posedge clk); #1;
    if (!keep) begin
      if (is_ext) ext_req = 0;
      else        core_req = 0;
    end
  endtask

  task automatic apply_reset();
    @(posedge clk); #1;
    reset = 0;
    exp_core_rd = '0;
    exp_ext_rd  = '0;
    repeat (2) @(posedge clk);
    #1 reset = 1;
  endtask

  typedef struct {
    int op;
    int rd;
    int rs1;
    int rs2;
    int imm;
  } ins_t;
  ins_t        prog [5];
  logic [31:0] xr [8];

  initial begin
    #200000;
    $display("FAIL global_timeout");
    $fatal(1, "bench timeout");
  end

  initial begin
    ins_t        ins;
    int          pc, ncyc;
    bit          pushed, stl;
    logic [31:0] rds, a, w;

    for (int i = 0; i < 16; i++) begin
      tmem[i] = '0;
      ref_mem[i] = '0;
    end

    // Reset state
    @(negedge clk);
    chk("rst_mem_en", mem_en, 0);
    chk("rst_mem_we", mem_we, 0);
    chk("rst_done", {core_done, ext_done}, 0);
    chk("rst_mem_addr", mem_addr, 0);
    chk("rst_mem_wdata", mem_wdata, 0);
    chk("rst_rdata", {core_rdata, ext_rdata}, 0);
    chk("rst_gnt_ext", gnt_ext, 1);
    @(posedge clk); #1 reset = 1;

    // Single core write
    push_exp(0, 1, 32'h4, 32'hF);
    core_req = 1; core_we = 1; core_addr = 32'h4; core_wdata = 32'hF;
    @(negedge clk);
    chk("wr_stall_n", core_stall, 1);
    chk("wr_en_n", mem_en, 0);
    @(negedge clk);
    chk("wr_en_n1", {mem_en, mem_we}, 2'b11);
    chk("wr_addr_n1", mem_addr, 32'h4);
    chk("wr_wdata_n1", mem_wdata, 32'hF);
    chk("wr_stall_n1", core_stall, 1);
    chk("wr_gnt_ext_n1", gnt_ext, 0);
    @(negedge clk);
    chk("wr_done_n2", core_done, 1);
    chk("wr_stall_n2", core_stall, 0);
    chk("wr_en_n2", mem_en, 0);
    @(posedge clk); #1 core_req = 0;
    chk("wr_mem", tmem[1], 32'hF);

    // Read latency, misaligned address
    tmem[1] = 32'hDEADBEEF;
    ref_mem[1] = 32'hDEADBEEF;
    push_exp(0, 0, 32'h6, 32'h0);
    core_req = 1; core_we = 0; core_addr = 32'h6;
    @(negedge clk);
    @(negedge clk);
    chk("rd_addr_n1", mem_addr, 32'h4);
    chk("rd_en_n1", {mem_en, mem_we}, 2'b10);
    @(negedge clk);
    chk("rd_done_n2", core_done, 1);
    chk("rd_data_n2", core_rdata, 32'hDEADBEEF);
    @(posedge clk); #1 core_req = 0;
    @(negedge clk);
    chk("rd_data_held", core_rdata, 32'hDEADBEEF);
    chk("rd_done_n3", core_done, 0);
    @(posedge clk); #1;

    // Back-to-back ext writes
    push_exp(1, 1, 32'h8, 32'h11);
    push_exp(1, 1, 32'hC, 32'h22);
    xfer(1, 1, 32'h8, 32'h11, 1);
    xfer(1, 1, 32'hC, 32'h22, 0);
    chk("b2b_mem8", tmem[2], 32'h11);
    chk("b2b_memC", tmem[3], 32'h22);
    chk("b2b_ext_rdata", ext_rdata, 0);

    // Contention from reset: core, ext, core, ext
    apply_reset();
    done_t.delete();
    push_exp(0, 0, 32'h4, 32'h0);
    push_exp(1, 0, 32'h8, 32'h0);
    push_exp(0, 1, 32'h14, 32'hA5);
    push_exp(1, 0, 32'hC, 32'h0);
    fork
      begin
        xfer(0, 0, 32'h4, 32'h0, 1);
        xfer(0, 1, 32'h14, 32'hA5, 0);
      end
      begin
        xfer(1, 0, 32'h8, 32'h0, 1);
        xfer(1, 0, 32'hC, 32'h0, 0);
      end
    join
    chk("cont_dones", done_t.size(), 4);
    if (done_t.size() == 4)
      for (int i = 1; i < 4; i++) chk("cont_spacing", done_t[i] - done_t[i-1], 3);
    chk("cont_gnt_ext", gnt_ext, 1);
    chk("cont_mem14", tmem[5], 32'hA5);
    chk("cont_ext_rdata", ext_rdata, 32'h22);

    // Program run: addi x1,7; addi x2,8; add x3; sw x3,0(x0); lw x6,0(x0)
    prog[0] = '{0, 1, 0, 0, 7};
    prog[1] = '{0, 2, 0, 0, 8};
    prog[2] = '{1, 3, 1, 2, 0};
    prog[3] = '{2, 0, 0, 3, 0};
    prog[4] = '{3, 6, 0, 0, 0};
    for (int i = 0; i < 8; i++) xr[i] = '0;
    pc = 0; ncyc = 0; pushed = 0;
    for (int t = 0; t < 60 && pc < 5; t++) begin
      ins = prog[pc];
      if (ins.op >= 2) begin
        a = xr[ins.rs1] + 32'(ins.imm);
        w = xr[ins.rs2];
        core_req = 1; core_we = (ins.op == 2); core_addr = a; core_wdata = w;
        if (!pushed) begin
          push_exp(0, ins.op == 2, a, w);
          pushed = 1;
        end
      end else core_req = 0;
      @(negedge clk);
      stl = core_stall;
      rds = core_rdata;
      @(posedge clk); #1;
      ncyc++;
      if (!stl) begin
        case (ins.op)
          0: xr[ins.rd] = xr[ins.rs1] + 32'(ins.imm);
          1: xr[ins.rd] = xr[ins.rs1] + xr[ins.rs2];
          3: xr[ins.rd] = rds;
          default: ;
        endcase
        xr[0] = '0;
        chk("pc_cycles", ncyc, (ins.op >= 2) ? 3 : 1);
        pc++; ncyc = 0; pushed = 0;
      end
    end
    core_req = 0;
    chk("prog_done", pc, 5);
    chk("prog_x6", xr[6], 32'd15);
    chk("prog_mem0", tmem[0], 32'd15);

    // Reset during ISSUE of a core store to 0x10
    tmem[4] = 32'h5555;
    ref_mem[4] = 32'h5555;
    core_req = 1; core_we = 1; core_addr = 32'h10; core_wdata = 32'h77;
    @(posedge clk);
    @(negedge clk);
    chk("rsti_in_issue", mem_en, 1);
    reset = 0;
    #1;
    chk("rsti_mem_en", mem_en, 0);
    chk("rsti_mem_we", mem_we, 0);
    chk("rsti_done", {core_done, ext_done}, 0);
    chk("rsti_mem_addr", mem_addr, 0);
    chk("rsti_mem_wdata", mem_wdata, 0);
    chk("rsti_core_rdata", core_rdata, 0);
    chk("rsti_ext_rdata", ext_rdata, 0);
    chk("rsti_gnt_ext", gnt_ext, 1);
    @(posedge clk);
    @(posedge clk); #1;
    chk("rsti_mem_kept", tmem[4], 32'h5555);
    core_req = 0;
    reset = 1;
    exp_core_rd = '0;
    exp_ext_rd = '0;
    repeat (4) @(posedge clk);
    #1 chk("sb_drained", sb.size(), 0);

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule
